pit_counter_block: RTL and testbench
====================================

// Module: pit_counter_block
// PURPOSE
//  8253/8254-compatible programmable interval timer: three 16-bit down-counters.
//  Sits directly downstream of the PIT clock-enable generator; counts on its 1.193182MHz
//  enable, iClkEnPit, inside the 10MHz iClk domain.
//  Ch0 out drives IRQ0. Ch2 out (gated by port 61h bit0) drives the speaker.
//  CPU sees I/O ports 40h-43h through iAddr.
// PARAMETERS
//  RESET_OUT  1'b0  level driven on oOut0..2 while iRst is high
// PORTS
//  iClk       in   1   system clock, 10MHz; the only clock
//  iRst       in   1   synchronous, active-high reset
//  iClkEnPit  in   1   one-iClk-wide count enable (tick), 1.193182MHz average
//  iAddr      in   2   0..2 = count reg of ch0..2, 3 = control word
//  iWr        in   1   one-cycle write strobe
//  iRd        in   1   one-cycle read strobe
//  iData      in   8   write data
//  oData      out  8   read data, registered; valid the cycle after iRd; holds until next iRd
//  iGate0/1/2 in   1   per-channel gate inputs
//  oOut0/1/2  out  1   per-channel counter outputs, registered
// BEHAVIOUR
//  Reset: every channel is unarmed, mode 0, access LSB/MSB (11), latch empty, both
//   read and write byte-toggles = LSB, count = 0. oOutN = RESET_OUT. oData = 0.
//  Control word (addr 3): [7:6] SC selects channel; SC=3 (read-back) is ignored.
//   [5:4] RW: 00 = latch, 01 = LSB only, 10 = MSB only, 11 = LSB then MSB.
//   [3:1] M: modes 6 and 7 alias modes 2 and 3; modes 1, 4, 5 execute as mode 0.
//   [0] BCD is ignored; the counters count binary only.
//  RW=00: copies the live count into the latch. No other state changes.
//   A second latch command while a latch is unread has no effect.
//  RW!=00: sets the mode and access mode, clears the byte-toggles, disarms the channel.
//   The output becomes low in mode 0 and high in modes 2/3. The counter freezes.
//  Count write: in access mode 11, LSB then MSB; a reload value of 0 means 65536.
//   The reload value is complete after the last byte.
//   Mode 0: out goes low on the first byte, then the channel rearms on completion.
//   Modes 2/3: if running, the new value takes effect at the next reload.
//   Otherwise it arms the channel.
//  Load: the first tick after arming loads the counter from the reload value.
//   That tick does not decrement.
//  Counting: only on ticks with gate=1.
//   Gate=0 forces out high in modes 2/3.
//   A rising gate in modes 2/3 reloads the counter on the next tick.
//  Mode 0: decrement by 1 per tick. Out goes high when count reaches 0 and stays high.
//   The count wraps 0 -> FFFF and keeps counting.
//   Out goes high N+1 ticks after the write completes.
//  Mode 2: decrement by 1. Out is low for exactly the one tick while count == 1.
//   The next tick reloads N and out goes high. Period = N ticks.
//  Mode 3: square wave. High phase = ceil(N/2) ticks, low phase = floor(N/2) ticks.
//   Out toggles at each phase end. N=1 behaves as constant high
//   (same as the real part: undefined; choose high).
//  Read (addr 0..2): returns the latch if it is full, otherwise the live count.
//   Byte order follows the access mode; the read byte-toggle advances on each iRd.
//   The latch frees after its last byte is read.
//   Reading addr 3 returns 8'hFF.
//  Simultaneous events: a write/read in the same cycle as a tick is applied first.
//   A control-word write suppresses that channel's tick.
//   iWr and iRd together in the same cycle: iWr wins and the read is ignored.
//  Reset mid-count: returns to the reset state on the next iClk. No partial state survives.
// STRUCTURE
//  Shared package: mode encodings (MODE0, MODE2, MODE3), RW encodings (RW_LATCH,
//   RW_LSB, RW_MSB, RW_WORD), port offsets (CTRL = 2'd3).
//  One sub-module, pit_channel, instanced 3 times. It holds: mode, rw, reload,
//   count, latch, the two toggles, the armed/load flags, and out.
//  The top level does address decode, control-word routing and the oData mux register.
// TESTING
//  1. Reset, write ctrl 36h, then ch0 = 00h,00h (65536), gate=1.
//     -> oOut0 = square wave of 32768 ticks high / 32768 ticks low.
//  2. Ctrl B6h, ch2 = 05h,00h.
//     -> oOut2 high for 3 ticks, low for 2 ticks, repeating.
//     Drop iGate2 -> oOut2 high and frozen.
//  3. Ctrl 34h, ch0 = 04h,00h.
//     -> oOut0 low exactly 1 tick out of every 4; the first low comes on tick 4 after load.
//  4. Ctrl 30h, ch0 = 03h,00h.
//     -> oOut0 is low from the LSB write and rises 4 ticks after the MSB write.
//     Then it stays high across the wrap.
//  5. Ctrl 34h, ch0 = 10h,00h. Let 3 ticks pass, then ctrl 00h.
//     Let more ticks pass, then read ch0 twice.
//     -> 0Eh, 00h (the latched value, not the live count).
//     The next read pair returns the live count.
//  6. Assert iWr (ctrl 34h) in the same cycle as iClkEnPit.
//     -> that tick is ignored. Assert iRst mid-count -> all outputs and state
//     return to reset values the next cycle.

Source files
------------

// File: rtl/pit_counter_block_pkg.sv
// rtl/pit_counter_block_pkg.sv - shared encodings for the programmable interval timer
// Purpose: mode and access-mode encodings, I/O port offsets and the control-word
//          mode decoder shared by pit_counter_block and pit_channel.
// Ports:   none (package)
package pit_counter_block_pkg;

    // Only three behaviours exist in this timer; every other mode folds onto these.
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } pit_mode_t;

    typedef enum logic [1:0] {
        RW_LATCH = 2'd0,
        RW_LSB   = 2'd1,
        RW_MSB   = 2'd2,
        RW_WORD  = 2'd3
    } pit_rw_t;

    localparam logic [1:0] CTRL   = 2'd3;
    localparam int         NUM_CH = 3;

    // Takes M[1:0] only: M[2] just separates 6/7 from their aliases 2/3 and
    // 4/5 from 0/1, so it never changes the result.
    function automatic pit_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b10:   return MODE2;
            2'b11:   return MODE3;
            default: return MODE0;
        endcase
    endfunction

endpackage

// File: rtl/pit_channel.sv
// rtl/pit_channel.sv - one 16-bit counter channel of the interval timer
// Purpose: holds mode, access mode, reload, count, latch, byte toggles,
//          armed/load flags and the channel output; counts on tick.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   tick            count enable from the PIT clock-enable generator
//   gate            channel gate input
//   ctrl_wr         control word addressed to this channel
//   ctrl_rw         RW field of that control word
//   ctrl_mode       decoded mode of that control word
//   cnt_wr, cnt_rd  count register write / read strobes
//   wdata           write data byte
//   out             registered channel output
//   rdata           byte a read of this channel would return now
module pit_channel
    import pit_counter_block_pkg::*;
#(
    parameter logic RESET_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gate,
    input  logic       ctrl_wr,
    input  logic [1:0] ctrl_rw,
    input  logic [1:0] ctrl_mode,
    input  logic       cnt_wr,
    input  logic       cnt_rd,
    input  logic [7:0] wdata,
    output logic       out,
    output logic [7:0] rdata
);

    pit_mode_t   mode, n_mode;
    logic [1:0]  rw, n_rw;
    logic [15:0] reload, n_reload;
    logic [7:0]  lsb_hold, n_lsb_hold;
    logic [15:0] count, n_count;
    logic [15:0] latch, n_latch;
    logic        latch_full, n_latch_full;
    logic        wr_msb, n_wr_msb;
    logic        rd_msb, n_rd_msb;
    logic        armed, n_armed;
    logic        load_pending, n_load_pending;
    logic        n_out;
    logic        gate_prev;

    logic        wr_done;
    logic [15:0] rd_value;
    logic [16:0] reload_full;
    logic [15:0] half_hi;
    logic [15:0] half_lo;

    // Read byte: latched value wins over the live count.
    always_comb begin
        rd_value = latch_full ? latch : count;
        case (rw)
            RW_MSB:  rdata = rd_value[15:8];
            RW_WORD: rdata = rd_msb ? rd_value[15:8] : rd_value[7:0];
            default: rdata = rd_value[7:0];
        endcase
    end

    // Bus access is resolved first; the tick then acts on the post-access state.
    always_comb begin
        n_mode         = mode;
        n_rw           = rw;
        n_reload       = reload;
        n_lsb_hold     = lsb_hold;
        n_count        = count;
        n_latch        = latch;
        n_latch_full   = latch_full;
        n_wr_msb       = wr_msb;
        n_rd_msb       = rd_msb;
        n_armed        = armed;
        n_load_pending = load_pending;
        n_out          = out;
        wr_done        = 1'b0;

        if (ctrl_wr) begin
            if (ctrl_rw == RW_LATCH) begin
                // A latch that is still unread is kept as is.
                if (!latch_full) begin
                    n_latch      = count;
                    n_latch_full = 1'b1;
                end
            end else begin
                n_mode         = pit_mode_t'(ctrl_mode);
                n_rw           = ctrl_rw;
                n_wr_msb       = 1'b0;
                n_rd_msb       = 1'b0;
                n_armed        = 1'b0;
                n_load_pending = 1'b0;
                n_out          = (pit_mode_t'(ctrl_mode) == MODE0) ? 1'b0 : 1'b1;
            end
        end else if (cnt_wr) begin
            case (rw)
                RW_LSB: begin
                    n_reload = {8'h00, wdata};
                    wr_done  = 1'b1;
                end
                RW_MSB: begin
                    n_reload = {wdata, 8'h00};
                    wr_done  = 1'b1;
                end
                default: begin
                    if (!wr_msb) begin
                        n_lsb_hold = wdata;
                        n_wr_msb   = 1'b1;
                        // Mode 0 stops and drops out as soon as a new value starts.
                        if (mode == MODE0) begin
                            n_out          = 1'b0;
                            n_armed        = 1'b0;
                            n_load_pending = 1'b0;
                        end
                    end else begin
                        n_reload = {wdata, lsb_hold};
                        n_wr_msb = 1'b0;
                        wr_done  = 1'b1;
                    end
                end
            endcase
            if (wr_done) begin
                if (mode == MODE0) begin
                    n_out          = 1'b0;
                    n_armed        = 1'b1;
                    n_load_pending = 1'b1;
                end else if (!armed) begin
                    // A running periodic channel picks the value up at its next reload.
                    n_armed        = 1'b1;
                    n_load_pending = 1'b1;
                end
            end
        end else if (cnt_rd) begin
            if (rw == RW_WORD) begin
                n_rd_msb = !rd_msb;
                if (rd_msb) begin
                    n_latch_full = 1'b0;
                end
            end else begin
                n_latch_full = 1'b0;
            end
        end

        // Periodic modes restart from the reload value after a rising gate.
        if (gate && !gate_prev && n_armed && (n_mode != MODE0)) begin
            n_load_pending = 1'b1;
        end

        // Reload of 0 stands for 65536; half periods come from the 17-bit value.
        reload_full = (n_reload == 16'd0) ? 17'h10000 : {1'b0, n_reload};
        half_lo     = reload_full[16:1];
        half_hi     = reload_full[16:1] + {15'd0, reload_full[0]};

        if (tick && !ctrl_wr && n_armed) begin
            if (n_load_pending) begin
                n_load_pending = 1'b0;
                case (n_mode)
                    MODE3: begin
                        n_count = half_hi;
                        n_out   = 1'b1;
                    end
                    MODE2: begin
                        n_count = n_reload;
                        n_out   = 1'b1;
                    end
                    default: n_count = n_reload;
                endcase
            end else if (gate) begin
                case (n_mode)
                    MODE2: begin
                        if (n_count == 16'd1) begin
                            n_count = n_reload;
                            n_out   = 1'b1;
                        end else begin
                            if (n_count == 16'd2) begin
                                n_out = 1'b0;
                            end
                            n_count = n_count - 16'd1;
                        end
                    end
                    MODE3: begin
                        // The current output level tells which half period ended.
                        if (n_count == 16'd1) begin
                            if (n_out && (half_lo != 16'd0)) begin
                                n_out   = 1'b0;
                                n_count = half_lo;
                            end else begin
                                n_out   = 1'b1;
                                n_count = half_hi;
                            end
                        end else begin
                            n_count = n_count - 16'd1;
                        end
                    end
                    default: begin
                        if (n_count == 16'd1) begin
                            n_out = 1'b1;
                        end
                        n_count = n_count - 16'd1;
                    end
                endcase
            end
        end

        if ((n_mode != MODE0) && !gate) begin
            n_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode         <= MODE0;
            rw           <= RW_WORD;
            reload       <= 16'd0;
            lsb_hold     <= 8'd0;
            count        <= 16'd0;
            latch        <= 16'd0;
            latch_full   <= 1'b0;
            wr_msb       <= 1'b0;
            rd_msb       <= 1'b0;
            armed        <= 1'b0;
            load_pending <= 1'b0;
            out          <= RESET_OUT;
            gate_prev    <= 1'b0;
        end else begin
            mode         <= n_mode;
            rw           <= n_rw;
            reload       <= n_reload;
            lsb_hold     <= n_lsb_hold;
            count        <= n_count;
            latch        <= n_latch;
            latch_full   <= n_latch_full;
            wr_msb       <= n_wr_msb;
            rd_msb       <= n_rd_msb;
            armed        <= n_armed;
            load_pending <= n_load_pending;
            out          <= n_out;
            gate_prev    <= gate;
        end
    end

endmodule

// File: rtl/pit_counter_block.sv
// rtl/pit_counter_block.sv - 8254-compatible three-channel interval timer
// Purpose: address decode, control-word routing to the three pit_channel
//          instances and the registered read-data mux.
// Ports:
//   iClk, iRst          10MHz clock, synchronous active-high reset
//   iClkEnPit           count tick
//   iAddr               0..2 count registers, 3 control word
//   iWr, iRd            write / read strobes (write wins when both are set)
//   iData, oData        write data, registered read data
//   iGate0..2           channel gates
//   oOut0..2            channel outputs
module pit_counter_block
    import pit_counter_block_pkg::*;
#(
    parameter logic RESET_OUT = 1'b0
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iClkEnPit,
    input  logic [1:0] iAddr,
    input  logic       iWr,
    input  logic       iRd,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    input  logic       iGate0,
    input  logic       iGate1,
    input  logic       iGate2,
    output logic       oOut0,
    output logic       oOut1,
    output logic       oOut2
);

    logic [NUM_CH-1:0]      gate_vec;
    logic [NUM_CH-1:0]      out_vec;
    logic [NUM_CH-1:0]      ctrl_wr;
    logic [NUM_CH-1:0]      cnt_wr;
    logic [NUM_CH-1:0]      cnt_rd;
    logic [NUM_CH-1:0][7:0] rbyte;
    logic                   ctrl_hit;
    logic                   rd_en;
    logic [1:0]             ctrl_mode;
    logic                   unused_bits;

    assign gate_vec = {iGate2, iGate1, iGate0};
    assign oOut0    = out_vec[0];
    assign oOut1    = out_vec[1];
    assign oOut2    = out_vec[2];

    assign ctrl_hit    = iWr && (iAddr == CTRL);
    assign rd_en       = iRd && !iWr;
    assign ctrl_mode   = decode_mode(iData[2:1]);
    // BCD select is not supported; M[2] never changes the decoded mode.
    assign unused_bits = ^{iData[3], iData[0]};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // SC = 3 (read-back) matches no channel and is dropped here.
        assign ctrl_wr[ch] = ctrl_hit && (iData[7:6] == 2'(ch));
        assign cnt_wr[ch]  = iWr && (iAddr == 2'(ch));
        assign cnt_rd[ch]  = rd_en && (iAddr == 2'(ch));

        pit_channel #(
            .RESET_OUT(RESET_OUT)
        ) u_ch (
            .clk      (iClk),
            .rst      (iRst),
            .tick     (iClkEnPit),
            .gate     (gate_vec[ch]),
            .ctrl_wr  (ctrl_wr[ch]),
            .ctrl_rw  (iData[5:4]),
            .ctrl_mode(ctrl_mode),
            .cnt_wr   (cnt_wr[ch]),
            .cnt_rd   (cnt_rd[ch]),
            .wdata    (iData),
            .out      (out_vec[ch]),
            .rdata    (rbyte[ch])
        );
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData <= 8'h00;
        end else if (rd_en) begin
            case (iAddr)
                2'd0:    oData <= rbyte[0];
                2'd1:    oData <= rbyte[1];
                2'd2:    oData <= rbyte[2];
                default: oData <= 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_pit_counter_block.sv
// tb/tb_pit_counter_block.sv - self-checking bench for pit_counter_block
module tb_pit_counter_block;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iClkEnPit = 1'b0;
    logic [1:0] iAddr = 2'd0;
    logic       iWr = 1'b0;
    logic       iRd = 1'b0;
    logic [7:0] iData = 8'h00;
    logic [7:0] oData;
    logic       iGate0 = 1'b1;
    logic       iGate1 = 1'b1;
    logic       iGate2 = 1'b1;
    logic       oOut0, oOut1, oOut2;

    int errors = 0;
    int checks = 0;

    always #5 iClk = ~iClk;

    pit_counter_block dut (
        .iClk(iClk), .iRst(iRst), .iClkEnPit(iClkEnPit), .iAddr(iAddr),
        .iWr(iWr), .iRd(iRd), .iData(iData), .oData(oData),
        .iGate0(iGate0), .iGate1(iGate1), .iGate2(iGate2),
        .oOut0(oOut0), .oOut1(oOut1), .oOut2(oOut2)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [1:0] addr;
        logic [7:0] data;
        logic       en;
        logic       o0, o1, o2;
        logic       cd;
        logic [7:0] ed;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t vw(logic [1:0] a, logic [7:0] d, logic o0, logic o1, logic o2);
        vec_t v = '{1'b1, 1'b0, a, d, 1'b0, o0, o1, o2, 1'b0, 8'h00};
        return v;
    endfunction

    function automatic vec_t vr(logic [1:0] a, logic [7:0] ed, logic o0, logic o1, logic o2);
        vec_t v = '{1'b0, 1'b1, a, 8'h00, 1'b0, o0, o1, o2, 1'b1, ed};
        return v;
    endfunction

    function automatic vec_t vt(logic o0, logic o1, logic o2);
        vec_t v = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, o0, o1, o2, 1'b0, 8'h00};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic en);
        iAddr = a; iData = d; iWr = 1'b1; iClkEnPit = en;
        step();
        iWr = 1'b0; iClkEnPit = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        iAddr = a; iRd = 1'b1;
        step();
        iRd = 1'b0;
    endtask

    task automatic tick();
        iClkEnPit = 1'b1;
        step();
        iClkEnPit = 1'b0;
    endtask

    int n;
    int k;

    initial begin
        // Reset state
        @(negedge iClk);
        step();
        step();
        chk("reset out0", oOut0, 1'b0);
        chk("reset out1", oOut1, 1'b0);
        chk("reset out2", oOut2, 1'b0);
        chk("reset data", oData, 8'h00);
        iRst = 1'b0;

        // Reads, control decode, mode 2 period, mode 0 rewrite/wrap, latch
        tv.push_back(vr(2'd1, 8'h00, 0, 0, 0));
        tv.push_back(vr(2'd1, 8'h00, 0, 0, 0));
        tv.push_back(vr(2'd3, 8'hFF, 0, 0, 0));
        tv.push_back(vw(2'd3, 8'h7C, 0, 1, 0));
        tv.push_back(vw(2'd3, 8'h72, 0, 0, 0));
        tv.push_back(vw(2'd3, 8'hF6, 0, 0, 0));
        tv.push_back(vw(2'd3, 8'h34, 1, 0, 0));
        tv.push_back(vw(2'd0, 8'h04, 1, 0, 0));
        tv.push_back(vw(2'd0, 8'h00, 1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vw(2'd3, 8'h30, 0, 0, 0));
        tv.push_back(vw(2'd0, 8'h03, 0, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vw(2'd0, 8'h00, 0, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vt(0, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vw(2'd3, 8'h00, 1, 0, 0));
        tv.push_back(vr(2'd0, 8'hFF, 1, 0, 0));
        tv.push_back(vr(2'd0, 8'hFF, 1, 0, 0));
        tv.push_back(vw(2'd3, 8'h34, 1, 0, 0));
        tv.push_back(vw(2'd0, 8'h10, 1, 0, 0));
        tv.push_back(vw(2'd0, 8'h00, 1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vw(2'd3, 8'h00, 1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vw(2'd3, 8'h00, 1, 0, 0));
        tv.push_back(vt(1, 0, 0));
        tv.push_back(vr(2'd0, 8'h0E, 1, 0, 0));
        tv.push_back(vr(2'd0, 8'h00, 1, 0, 0));
        tv.push_back(vr(2'd0, 8'h0C, 1, 0, 0));
        tv.push_back(vr(2'd0, 8'h00, 1, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            iWr = tv[i].wr; iRd = tv[i].rd; iAddr = tv[i].addr;
            iData = tv[i].data; iClkEnPit = tv[i].en;
            step();
            iWr = 1'b0; iRd = 1'b0; iClkEnPit = 1'b0;
            chk($sformatf("v%0d out0", i), oOut0, tv[i].o0);
            chk($sformatf("v%0d out1", i), oOut1, tv[i].o1);
            chk($sformatf("v%0d out2", i), oOut2, tv[i].o2);
            if (tv[i].cd) chk($sformatf("v%0d data", i), oData, tv[i].ed);
        end

        // Mode 3 on ch2, N=5: 3 high / 2 low, gate low freezes high, gate rise restarts
        wr(2'd3, 8'hB6, 1'b0);
        chk("sq2 ctrl out2", oOut2, 1'b1);
        wr(2'd2, 8'h05, 1'b0);
        wr(2'd2, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("sq2 t%0d", i), oOut2, ((i % 5) < 3) ? 1'b1 : 1'b0);
        end
        iGate2 = 1'b0;
        step();
        chk("sq2 gate low", oOut2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sq2 frozen t%0d", i), oOut2, 1'b1);
        end
        iGate2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("sq2 regate t%0d", i), oOut2, ((i % 5) < 3) ? 1'b1 : 1'b0);
        end

        // Mode 3 on ch0 with reload 0 (65536): 32768 high / 32768 low
        wr(2'd3, 8'h36, 1'b0);
        chk("sq0 ctrl out0", oOut0, 1'b1);
        wr(2'd0, 8'h00, 1'b0);
        wr(2'd0, 8'h00, 1'b0);
        iClkEnPit = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (oOut0 && n < 40000);
        chk("sq0 high ticks", n - 1, 32768);
        k = 0;
        do begin
            step();
            k++;
        end while (!oOut0 && k < 40000);
        chk("sq0 low ticks", k, 32768);
        iClkEnPit = 1'b0;

        // Same-cycle tick: write completes first, control write swallows the tick
        wr(2'd3, 8'h34, 1'b1);
        wr(2'd0, 8'h03, 1'b0);
        wr(2'd0, 8'h00, 1'b1);
        chk("coin load out0", oOut0, 1'b1);
        tick();
        chk("coin t2 out0", oOut0, 1'b1);
        tick();
        chk("coin t3 out0", oOut0, 1'b0);
        tick();
        chk("coin reload out0", oOut0, 1'b1);
        tick();
        wr(2'd3, 8'h00, 1'b1);
        rd(2'd0);
        chk("coin latch lsb", oData, 8'h02);
        rd(2'd0);
        chk("coin latch msb", oData, 8'h00);
        rd(2'd0);
        chk("coin live lsb", oData, 8'h02);
        rd(2'd0);
        chk("coin live msb", oData, 8'h00);

        // Write and read together: the read is dropped
        iAddr = 2'd3; iData = 8'h40; iWr = 1'b1; iRd = 1'b1;
        step();
        iWr = 1'b0; iRd = 1'b0;
        chk("wr+rd data held", oData, 8'h00);
        rd(2'd3);
        chk("ctrl read", oData, 8'hFF);

        // Reset while counting
        iRst = 1'b1; iClkEnPit = 1'b1;
        step();
        chk("rst out0", oOut0, 1'b0);
        chk("rst out1", oOut1, 1'b0);
        chk("rst out2", oOut2, 1'b0);
        chk("rst data", oData, 8'h00);
        iRst = 1'b0;
        step();
        step();
        iClkEnPit = 1'b0;
        chk("post rst out0", oOut0, 1'b0);
        chk("post rst out2", oOut2, 1'b0);
        rd(2'd0);
        chk("post rst lsb", oData, 8'h00);
        rd(2'd0);
        chk("post rst msb", oData, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
